// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM encoding and operand-sign helpers for the RV32M multiply/divide sequencer.
package muldiv_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic op_a_signed(input logic [2:0] f);
        return (f == OP_MULH) || (f == OP_MULHSU) || (f == OP_DIV) || (f == OP_REM);
    endfunction

    // REM needs |rs2| for the iteration even though the divisor sign never reaches the result.
    function automatic logic op_b_signed(input logic [2:0] f);
        return (f == OP_MULH) || (f == OP_DIV) || (f == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial remainder, subtract if it fits.
module muldiv_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] div_i,
    input  logic            bit_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_o
);

    logic [XLEN:0] shifted_s;
    logic [XLEN:0] diff_s;

    // Trial subtraction; the partial remainder stays below the divisor so XLEN bits always suffice.
    always_comb begin
        shifted_s = {rem_i, bit_i};
        diff_s    = shifted_s - {1'b0, div_i};
        if (shifted_s >= {1'b0, div_i}) begin
            q_o   = 1'b1;
            rem_o = diff_s[XLEN-1:0];
        end else begin
            q_o   = 1'b0;
            rem_o = shifted_s[XLEN-1:0];
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer with pipeline stall and one-cycle done pulse.
// Optional MULDIV_FAST_MUL_EN: multiplies complete in one cycle through a combinational multiplier.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic            neg_q, neg_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            a_neg_s, b_neg_s, neg_in_s;
    logic [XLEN-1:0] abs_a_s, abs_b_s;
    logic            div_zero_s, ovf_s;
    logic [XLEN-1:0] fast_div_res_s;
    logic [XLEN:0]   add_s;
    logic [XLEN-1:0] step_rem_s;
    logic            step_q_s;
    logic [2*XLEN-1:0] prod_s, prod_fix_s;
    logic [XLEN-1:0] div_sel_s, fix_res_s;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod_s, fast_prod_fix_s;
    logic [XLEN-1:0]   fast_mul_res_s;
`endif

    muldiv_div_step #(.XLEN(XLEN)) u_div_step (
        .rem_i (hi_q),
        .div_i (b_q),
        .bit_i (lo_q[XLEN-1]),
        .rem_o (step_rem_s),
        .q_o   (step_q_s)
    );

    // Operand magnitudes, result sign and the divide fast-path outcomes for the request on the inputs.
    always_comb begin
        a_neg_s    = op_a[XLEN-1] & op_a_signed(funct3);
        b_neg_s    = op_b[XLEN-1] & op_b_signed(funct3);
        neg_in_s   = a_neg_s ^ (b_neg_s & (funct3 != OP_REM));
        abs_a_s    = a_neg_s ? ({XLEN{1'b0}} - op_a) : op_a;
        abs_b_s    = b_neg_s ? ({XLEN{1'b0}} - op_b) : op_b;
        div_zero_s = (op_b == {XLEN{1'b0}});
        ovf_s      = ((funct3 == OP_DIV) || (funct3 == OP_REM))
                     && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (&op_b);
        if (funct3[1]) begin
            fast_div_res_s = div_zero_s ? op_a : {XLEN{1'b0}};
        end else begin
            fast_div_res_s = div_zero_s ? {XLEN{1'b1}} : op_a;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    // Single-cycle product of the magnitudes, sign applied afterwards like the iterative path.
    always_comb begin
        fast_prod_s     = {{XLEN{1'b0}}, abs_a_s} * {{XLEN{1'b0}}, abs_b_s};
        fast_prod_fix_s = neg_in_s ? ({(2*XLEN){1'b0}} - fast_prod_s) : fast_prod_s;
        if (funct3 == OP_MUL) begin
            fast_mul_res_s = fast_prod_fix_s[XLEN-1:0];
        end else begin
            fast_mul_res_s = fast_prod_fix_s[2*XLEN-1:XLEN];
        end
    end
`endif

    // Shift-add datapath and the sign fix applied in FIX.
    always_comb begin
        add_s      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
        prod_s     = {hi_q, lo_q};
        prod_fix_s = neg_q ? ({(2*XLEN){1'b0}} - prod_s) : prod_s;
        div_sel_s  = op_q[1] ? hi_q : lo_q;
        if (op_q[2]) begin
            fix_res_s = neg_q ? ({XLEN{1'b0}} - div_sel_s) : div_sel_s;
        end else if (op_q == OP_MUL) begin
            fix_res_s = prod_fix_s[XLEN-1:0];
        end else begin
            fix_res_s = prod_fix_s[2*XLEN-1:XLEN];
        end
    end

    // Next-state logic: multiply keeps {hi,lo} as the product shifting right, divide keeps hi=remainder, lo=dividend/quotient.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    op_d  = funct3;
                    neg_d = neg_in_s;
                    cnt_d = {CW{1'b0}};
                    if (funct3[2] && (div_zero_s || ovf_s)) begin
                        state_d  = DONE;
                        result_d = fast_div_res_s;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (!funct3[2]) begin
                        state_d  = DONE;
                        result_d = fast_mul_res_s;
                    end
`endif
                    else begin
                        state_d = CALC;
                        hi_d    = {XLEN{1'b0}};
                        if (funct3[2]) begin
                            lo_d = abs_a_s;
                            b_d  = abs_b_s;
                        end else begin
                            lo_d = abs_b_s;
                            b_d  = abs_a_s;
                        end
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    if (op_q[2]) begin
                        hi_d = step_rem_s;
                        lo_d = {lo_q[XLEN-2:0], step_q_s};
                    end else begin
                        hi_d = add_s[XLEN:1];
                        lo_d = {add_s[0], lo_q[XLEN-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(XLEN-1)) begin
                        state_d = FIX;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            FIX: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    state_d  = DONE;
                    result_d = fix_res_s;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and datapath registers; reset clears everything and aborts any op in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= {CW{1'b0}};
            op_q     <= 3'd0;
            neg_q    <= 1'b0;
            hi_q     <= {XLEN{1'b0}};
            lo_q     <= {XLEN{1'b0}};
            b_q      <= {XLEN{1'b0}};
            result_q <= {XLEN{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign stall  = (start & (state_q == IDLE)) | (busy_q & (state_q != DONE));

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table with scoreboard plus flush/reset/back-to-back sequences.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic        busy, stall, done;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t scb[$];
    vec_t vecs[20];

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        logic signed [31:0] as32, bs32;
        logic ovf;
        sa   = {{32{a[31]}}, a};
        sb   = {{32{b[31]}}, b};
        ua   = {32'd0, a};
        ub   = {32'd0, b};
        as32 = a;
        bs32 = b;
        ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return (b == 32'd0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(as32 / bs32));
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 32'd0) ? a : (ovf ? 32'd0 : 32'(as32 % bs32));
            3'd7: return (b == 32'd0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) return FAST ? 1 : 34;
        if (b == 32'd0) return 1;
        if (((f == 3'd4) || (f == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
        return 34;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    task automatic drive_start(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        start  = 1'b1;
        funct3 = f;
        op_a   = a;
        op_b   = b;
        e.res  = ref_op(f, a, b);
        e.lat  = exp_lat(f, a, b);
        scb.push_back(e);
    endtask

    // Waits for done, compares against the scoreboard; optionally issues the next request in the done cycle.
    task automatic wait_done(input string name, input int extra, input bit chain,
                             input logic [2:0] nf, input logic [31:0] na, input logic [31:0] nb);
        exp_t e;
        int   cyc;
        bit   stall_ok;
        e        = scb.pop_front();
        cyc      = 0;
        stall_ok = 1'b1;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) break;
            if (stall !== 1'b1) stall_ok = 1'b0;
        end
        if (done !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL %s timeout: no done within %0d cycles", name, cyc);
            start = 1'b0;
            return;
        end
        if (stall !== 1'b0) stall_ok = 1'b0;
        check({name, " result"}, result, e.res);
        check({name, " latency"}, 32'(cyc), 32'(e.lat + extra));
        check({name, " stall"}, {31'd0, stall_ok}, 32'd1);
        if (chain) begin
            drive_start(nf, na, nb);
        end else begin
            start = 1'b0;
            @(negedge clk);
            check({name, " done pulse"}, {31'd0, done}, 32'd0);
            check({name, " result held"}, result, e.res);
        end
    endtask

    initial begin
        int          k;
        int          got;
        bit          saw_done;
        logic [31:0] last_res;
        exp_t        e;

        rst = 1'b1; start = 1'b0; flush = 1'b0;
        funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0;
        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle stall", {31'd0, stall}, 32'd0);

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2};
        vecs[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF};
        vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5};
        vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
        vecs[12] = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF};
        vecs[13] = '{3'd7, 32'h0000_1234,  32'd0,         32'h0000_1234};
        for (int i = 14; i < 20; i++) begin
            vecs[i].f = 3'($urandom_range(0, 7));
            vecs[i].a = $urandom;
            vecs[i].b = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            vecs[i].exp = ref_op(vecs[i].f, vecs[i].a, vecs[i].b);
        end

        for (int i = 0; i < 20; i++) begin
            check($sformatf("vec%0d model", i), ref_op(vecs[i].f, vecs[i].a, vecs[i].b), vecs[i].exp);
            drive_start(vecs[i].f, vecs[i].a, vecs[i].b);
            #1;
            check($sformatf("vec%0d stall@t", i), {31'd0, stall}, 32'd1);
            wait_done($sformatf("vec%0d", i), 0, 1'b0, 3'd0, 32'd0, 32'd0);
        end

        // A start pulse while busy must not disturb the accepted DIVU even though the inputs change.
        drive_start(3'd5, 32'd100, 32'd7);
        got = 0;
        for (k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 5) begin start = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd3; end
            if (k == 6) start = 1'b0;
            if (done === 1'b1) begin got = k; break; end
        end
        e = scb.pop_front();
        check("ignore result", result, e.res);
        check("ignore latency", 32'(got), 32'd34);
        @(negedge clk);
        check("ignore no re-done", {31'd0, done}, 32'd0);
        last_res = e.res;

        // Flush at t+10 abandons the DIV: busy drops, no done, result keeps the previous value.
        start = 1'b1; funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd3;
        saw_done = 1'b0;
        for (k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 10) flush = 1'b1;
            if (k == 11) begin
                flush = 1'b0;
                check("flush busy", {31'd0, busy}, 32'd0);
            end
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("flush no done", {31'd0, saw_done}, 32'd0);
        check("flush result", result, last_res);

        // Reset at t+20 mid-MUL clears the visible state on the next cycle.
        start = 1'b1; funct3 = 3'd0; op_a = 32'd7; op_b = 32'hFFFF_FFFD;
        for (k = 1; k <= 21; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 20) rst = 1'b1;
        end
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back: the second MUL is presented in the done cycle and accepted in the following IDLE cycle.
        drive_start(3'd0, 32'd7, 32'hFFFF_FFFD);
        wait_done("b2b first", 0, 1'b1, 3'd0, 32'd5, 32'd6);
        wait_done("b2b second", 1, 1'b0, 3'd0, 32'd0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
